mem_ctrl_arbiter: RTL and testbench
===================================

Name: mem_ctrl_arbiter

Overview:
Shares the single main-memory controller port between the I-cache miss path (read-only) and the D-cache miss/writeback path (read/write). Sits at core top level, between the cores' icache/dcache mem-ctrl request/response interfaces and the main memory. It is a blocking, single-outstanding-transaction arbiter with round-robin fairness. Request fields are latched at grant, and the response is steered back to the owning cache.

Parameters:
BLOCK_ADDR_W, 26, block address width (32-bit byte address, 64 B block); equals width of main_mem_block_addr_t
BLOCK_DATA_W, 512, block data width; equals width of block_data_t
RESET_PRIO_DCACHE, 1, round-robin pointer value at reset (1: D-cache wins the first tie)

Ports:
clk  in  1  clock
rst_aL  in  1  synchronous active-low reset
ic_req_valid  in  1  I-cache read request
ic_req_block_addr  in  BLOCK_ADDR_W  I-cache block address
ic_req_ready  out  1  I-cache request accepted this cycle
ic_resp_valid  out  1  I-cache fill data valid (1-cycle pulse)
ic_resp_block_data  out  BLOCK_DATA_W  I-cache fill data
dc_req_valid  in  1  D-cache request
dc_req_type  in  1  req_type_t (0 read, 1 write)
dc_req_block_addr  in  BLOCK_ADDR_W  D-cache block address
dc_req_block_data  in  BLOCK_DATA_W  writeback data
dc_req_ready  out  1  D-cache request accepted this cycle
dc_resp_valid  out  1  D-cache read data / write ack (1-cycle pulse)
dc_resp_block_data  out  BLOCK_DATA_W  D-cache read data (don't-care for writes)
mem_req_valid  out  1  request to main memory
mem_req_type  out  1  0 read, 1 write
mem_req_block_addr  out  BLOCK_ADDR_W  latched address
mem_req_block_data  out  BLOCK_DATA_W  latched write data
mem_req_ready  in  1  main memory accepts request
mem_resp_valid  in  1  main memory response (reads and write acks)
mem_resp_block_data  in  BLOCK_DATA_W  response data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. rst_aL is synchronous, active-low, and sampled on the rising clk edge.
- Reset values: state=IDLE; owner=IC; rr_ptr=RESET_PRIO_DCACHE; all latched request regs=0; every valid/ready output=0; busy=0.
- Reset mid-transaction returns the block to IDLE. Any response arriving afterwards is dropped; no resp pulse is issued.
- FSM states: IDLE -> ISSUE -> WAIT_RESP -> IDLE.
- IDLE:
  - Grant is combinational. Only one requester valid: that one wins.
  - Both valid: rr_ptr decides (1 = D-cache).
  - The winner's *_req_ready=1 in the same cycle. The loser's ready stays 0 and it must hold its valid.
  - On grant: latch type (forced to read for IC), address and data; set owner; set rr_ptr to point at the loser side (rr_ptr <= ~granted_is_dc); next state ISSUE.
- ISSUE:
  - mem_req_valid=1 and all mem_req_* fields driven from the latches; fields are stable until accepted.
  - When mem_req_ready=1: next state WAIT_RESP.
- WAIT_RESP:
  - When mem_resp_valid=1, forward combinationally to the owner: ic_resp_valid or dc_resp_valid=1 in the same cycle, with data passed through.
  - Next state IDLE. A new grant is possible the following cycle.
- Minimum occupancy per transaction: 3 cycles (grant, issue, response), plus memory latency.
- mem_resp_valid in IDLE or ISSUE is ignored and flagged by an assertion.
- Requester ready is 0 in every state except IDLE.
- The non-owner's resp_valid is always 0.
- resp_block_data outputs are don't-care when the matching valid is 0; drive 0 when invalid.
- No cancellation: an accepted I-cache request completes even across a fetch redirect. Dropping stale fill data is the IFU's job.
- busy=1 in ISSUE and WAIT_RESP.

Decomposition:
- req_type_t, main_mem_block_addr_t, block_data_t and a new arb_owner_t enum {ARB_OWNER_IC, ARB_OWNER_DC} belong in the shared global defs package.
- A FSM state enum is local to the module.
- The round-robin grant logic is the one natural sub-module: rr_arbiter2 (inputs: two requests, pointer, enable; outputs: one-hot grant, next pointer).

Test Plan:
1. Reset, then IC-only read: ic_req_valid=1, addr=0x0000040, mem_req_ready=1, memory responds after 5 cycles with data=0xA5... -> ic_req_ready=1 at cycle 0; mem_req_valid at cycle 1 with addr=0x0000040 and type=0; ic_resp_valid pulse carrying the data; dc_resp_valid stays 0.
2. Simultaneous requests after reset (RESET_PRIO_DCACHE=1): IC addr 0x10, DC read addr 0x20, both held -> DC granted first and served; IC granted on the next IDLE cycle; a third simultaneous pair is granted to DC again (alternation).
3. DC write: type=1, addr=0x3FF, data=0xDEADBEEF... -> mem_req_type=1 and mem_req_block_data matches; dc_resp_valid pulses on the ack; ic outputs quiet.
4. Backpressure: mem_req_ready=0 for 4 cycles. The DC drops dc_req_valid and changes addr after grant -> mem_req fields stay at the latched values for all 4 cycles; no new grant occurs.
5. Reset mid-transaction: assert rst_aL=0 in WAIT_RESP, release, then inject mem_resp_valid=1 -> no resp pulse; busy=0; state IDLE.
6. Spurious mem_resp_valid in IDLE -> no resp pulse; assertion fires; the next request is serviced normally.

Source files
------------

// File: rtl/mem_ctrl_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_arbiter_pkg
// Brief    : Shared types for the main-memory controller port and its arbiter
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_arbiter_pkg;

   // 32-bit byte address split into 64 B blocks
   localparam int unsigned MEM_BLOCK_ADDR_W = 26;
   localparam int unsigned MEM_BLOCK_DATA_W = 512;

   typedef logic [MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
   typedef logic [MEM_BLOCK_DATA_W-1:0] block_data_t;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_type_t;

   // Which cache owns the transaction currently in flight
   typedef enum logic {
      ARB_OWNER_IC = 1'b0,
      ARB_OWNER_DC = 1'b1
   } arb_owner_t;

endpackage : mem_ctrl_arbiter_pkg
`default_nettype wire

// File: rtl/mem_ctrl_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant. Bit 0 = I-cache, bit 1 = D-cache.
//            A pointer of 1 favours the D-cache on a tie. After any grant the
//            pointer moves to the side that did not win.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
   input  logic       req_ic_i,
   input  logic       req_dc_i,
   input  logic       ptr_i,
   input  logic       en_i,
   output logic [1:0] gnt_o,
   output logic       ptr_next_o
);

   logic gnt_ic;
   logic gnt_dc;

   // One-hot grant: a lone requester always wins, the pointer breaks ties
   always_comb begin
      gnt_dc     = en_i & req_dc_i & (~req_ic_i | ptr_i);
      gnt_ic     = en_i & req_ic_i & (~req_dc_i | ~ptr_i);
      gnt_o      = {gnt_dc, gnt_ic};
      ptr_next_o = ptr_i;
      if (gnt_dc) begin
         ptr_next_o = 1'b0;
      end else if (gnt_ic) begin
         ptr_next_o = 1'b1;
      end
   end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_arbiter
// Brief    : Shares the single main-memory port between the I-cache miss path
//            (read-only) and the D-cache miss/writeback path. Blocking, one
//            transaction in flight, round-robin fair. Request fields are
//            latched at grant and the response is steered back to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter
   import mem_ctrl_arbiter_pkg::*;
#(
   parameter int unsigned BLOCK_ADDR_W      = MEM_BLOCK_ADDR_W,
   parameter int unsigned BLOCK_DATA_W      = MEM_BLOCK_DATA_W,
   parameter bit          RESET_PRIO_DCACHE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_aL,

   input  logic                    ic_req_valid,
   input  logic [BLOCK_ADDR_W-1:0] ic_req_block_addr,
   output logic                    ic_req_ready,
   output logic                    ic_resp_valid,
   output logic [BLOCK_DATA_W-1:0] ic_resp_block_data,

   input  logic                    dc_req_valid,
   input  logic                    dc_req_type,
   input  logic [BLOCK_ADDR_W-1:0] dc_req_block_addr,
   input  logic [BLOCK_DATA_W-1:0] dc_req_block_data,
   output logic                    dc_req_ready,
   output logic                    dc_resp_valid,
   output logic [BLOCK_DATA_W-1:0] dc_resp_block_data,

   output logic                    mem_req_valid,
   output logic                    mem_req_type,
   output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
   output logic [BLOCK_DATA_W-1:0] mem_req_block_data,
   input  logic                    mem_req_ready,
   input  logic                    mem_resp_valid,
   input  logic [BLOCK_DATA_W-1:0] mem_resp_block_data,

   output logic                    busy
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_RESP = 2'd2
   } state_t;

   state_t                  state_q;
   arb_owner_t              owner_q;
   logic                    rr_ptr_q;
   logic                    rr_ptr_d;
   req_type_t               type_q;
   logic [BLOCK_ADDR_W-1:0] addr_q;
   logic [BLOCK_DATA_W-1:0] data_q;
   logic                    mem_req_valid_q;
   logic                    busy_q;

   logic                    arb_en;
   logic [1:0]              gnt;
   logic                    resp_fwd;

   // Arbitration is only live in IDLE and out of reset, so ready is never
   // raised while a transaction is in flight or reset is asserted
   assign arb_en = rst_aL & (state_q == ST_IDLE);

   rr_arbiter2 u_rr_arbiter2 (
      .req_ic_i   (ic_req_valid),
      .req_dc_i   (dc_req_valid),
      .ptr_i      (rr_ptr_q),
      .en_i       (arb_en),
      .gnt_o      (gnt),
      .ptr_next_o (rr_ptr_d)
   );

   assign ic_req_ready = gnt[0];
   assign dc_req_ready = gnt[1];

   // Response is only honoured while waiting for one; anything else is dropped
   assign resp_fwd = rst_aL & (state_q == ST_WAIT_RESP) & mem_resp_valid;

   // Steer the memory response to whichever cache owns the transaction
   always_comb begin
      ic_resp_valid      = 1'b0;
      dc_resp_valid      = 1'b0;
      ic_resp_block_data = '0;
      dc_resp_block_data = '0;
      if (resp_fwd) begin
         if (owner_q == ARB_OWNER_DC) begin
            dc_resp_valid      = 1'b1;
            dc_resp_block_data = mem_resp_block_data;
         end else begin
            ic_resp_valid      = 1'b1;
            ic_resp_block_data = mem_resp_block_data;
         end
      end
   end

   assign mem_req_valid      = mem_req_valid_q;
   assign mem_req_type       = type_q;
   assign mem_req_block_addr = addr_q;
   assign mem_req_block_data = data_q;
   assign busy               = busy_q;

   // Transaction FSM: latch the winner at grant, hold it until memory
   // accepts, then wait for the single response
   always_ff @(posedge clk) begin
      if (!rst_aL) begin
         state_q         <= ST_IDLE;
         owner_q         <= ARB_OWNER_IC;
         rr_ptr_q        <= RESET_PRIO_DCACHE;
         type_q          <= REQ_READ;
         addr_q          <= '0;
         data_q          <= '0;
         mem_req_valid_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt != 2'b00) begin
                  rr_ptr_q        <= rr_ptr_d;
                  mem_req_valid_q <= 1'b1;
                  busy_q          <= 1'b1;
                  state_q         <= ST_ISSUE;
                  if (gnt[1]) begin
                     owner_q <= ARB_OWNER_DC;
                     type_q  <= req_type_t'(dc_req_type);
                     addr_q  <= dc_req_block_addr;
                     data_q  <= dc_req_block_data;
                  end else begin
                     // I-cache path is read-only
                     owner_q <= ARB_OWNER_IC;
                     type_q  <= REQ_READ;
                     addr_q  <= ic_req_block_addr;
                     data_q  <= '0;
                  end
               end
            end
            ST_ISSUE: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= ST_WAIT_RESP;
               end
            end
            ST_WAIT_RESP: begin
               if (mem_resp_valid) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               mem_req_valid_q <= 1'b0;
               busy_q          <= 1'b0;
               state_q         <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   // Memory should only respond while a transaction is waiting for it
   always @(posedge clk) begin
      if (rst_aL && mem_resp_valid) begin
         assert (state_q == ST_WAIT_RESP)
            else $warning("mem_ctrl_arbiter: spurious mem_resp_valid outside WAIT_RESP dropped");
      end
   end
`endif

endmodule : mem_ctrl_arbiter
`default_nettype wire

// File: tb/tb_mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl_arbiter
// Brief    : Directed scoreboard bench for mem_ctrl_arbiter
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arbiter;
   import mem_ctrl_arbiter_pkg::*;

   localparam int AW = 26;
   localparam int DW = 512;

   logic          clk;
   logic          rst_aL;
   logic          ic_req_valid;
   logic [AW-1:0] ic_req_block_addr;
   logic          ic_req_ready;
   logic          ic_resp_valid;
   logic [DW-1:0] ic_resp_block_data;
   logic          dc_req_valid;
   logic          dc_req_type;
   logic [AW-1:0] dc_req_block_addr;
   logic [DW-1:0] dc_req_block_data;
   logic          dc_req_ready;
   logic          dc_resp_valid;
   logic [DW-1:0] dc_resp_block_data;
   logic          mem_req_valid;
   logic          mem_req_type;
   logic [AW-1:0] mem_req_block_addr;
   logic [DW-1:0] mem_req_block_data;
   logic          mem_req_ready;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_block_data;
   logic          busy;

   mem_ctrl_arbiter #(
      .BLOCK_ADDR_W      (AW),
      .BLOCK_DATA_W      (DW),
      .RESET_PRIO_DCACHE (1'b1)
   ) dut (
      .clk                 (clk),
      .rst_aL              (rst_aL),
      .ic_req_valid        (ic_req_valid),
      .ic_req_block_addr   (ic_req_block_addr),
      .ic_req_ready        (ic_req_ready),
      .ic_resp_valid       (ic_resp_valid),
      .ic_resp_block_data  (ic_resp_block_data),
      .dc_req_valid        (dc_req_valid),
      .dc_req_type         (dc_req_type),
      .dc_req_block_addr   (dc_req_block_addr),
      .dc_req_block_data   (dc_req_block_data),
      .dc_req_ready        (dc_req_ready),
      .dc_resp_valid       (dc_resp_valid),
      .dc_resp_block_data  (dc_resp_block_data),
      .mem_req_valid       (mem_req_valid),
      .mem_req_type        (mem_req_type),
      .mem_req_block_addr  (mem_req_block_addr),
      .mem_req_block_data  (mem_req_block_data),
      .mem_req_ready       (mem_req_ready),
      .mem_resp_valid      (mem_resp_valid),
      .mem_resp_block_data (mem_resp_block_data),
      .busy                (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          typ;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            chk_data;
   } exp_mem_t;

   typedef struct {
      bit            is_dc;
      logic [DW-1:0] data;
   } exp_resp_t;

   exp_mem_t  exp_mem_q[$];
   exp_resp_t exp_resp_q[$];
   exp_mem_t  em;
   exp_resp_t er;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Scoreboard monitor: compares every accepted memory request and every
   // response pulse against the next queued expectation
   always @(negedge clk) begin
      if (rst_aL === 1'b1) begin
         if (mem_req_valid && mem_req_ready) begin
            if (exp_mem_q.size() == 0) begin
               fail("mem_req_unexpected");
            end else begin
               em = exp_mem_q.pop_front();
               chk("mem_req_type", mem_req_type, em.typ);
               chk("mem_req_addr", mem_req_block_addr, em.addr);
               if (em.chk_data) chk("mem_req_data", mem_req_block_data, em.data);
            end
         end
         if (ic_resp_valid || dc_resp_valid) begin
            chk("resp_both_valid", ic_resp_valid & dc_resp_valid, 0);
            if (exp_resp_q.size() == 0) begin
               fail("resp_unexpected");
            end else begin
               er = exp_resp_q.pop_front();
               chk("resp_owner_dc", dc_resp_valid, er.is_dc);
               chk("resp_data", er.is_dc ? dc_resp_block_data : ic_resp_block_data, er.data);
               chk("resp_other_data_zero", er.is_dc ? ic_resp_block_data : dc_resp_block_data, 0);
            end
         end
      end
   end

   task automatic push_mem(input logic typ, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input bit chk_data);
      exp_mem_t e;
      e.typ = typ; e.addr = addr; e.data = data; e.chk_data = chk_data;
      exp_mem_q.push_back(e);
   endtask

   task automatic push_resp(input bit is_dc, input logic [DW-1:0] data);
      exp_resp_t e;
      e.is_dc = is_dc; e.data = data;
      exp_resp_q.push_back(e);
   endtask

   // I-cache requester: hold valid until granted, then drop it
   task automatic ic_request(input logic [AW-1:0] addr);
      int n = 0;
      ic_req_valid      = 1'b1;
      ic_req_block_addr = addr;
      do begin
         @(negedge clk);
         n++;
      end while (!ic_req_ready && n < 60);
      if (!ic_req_ready) fail("ic_grant_timeout");
      else chk("ic_grant_mem_idle", mem_req_valid, 0);
      @(posedge clk); #1;
      ic_req_valid      = 1'b0;
      ic_req_block_addr = 26'h3A5A5A5;
   endtask

   // D-cache requester: hold until granted, then drop and scramble fields
   task automatic dc_request(input logic typ, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n = 0;
      dc_req_valid      = 1'b1;
      dc_req_type       = typ;
      dc_req_block_addr = addr;
      dc_req_block_data = data;
      do begin
         @(negedge clk);
         n++;
      end while (!dc_req_ready && n < 60);
      if (!dc_req_ready) fail("dc_grant_timeout");
      else chk("dc_grant_mem_idle", mem_req_valid, 0);
      @(posedge clk); #1;
      dc_req_valid      = 1'b0;
      dc_req_type       = ~typ;
      dc_req_block_addr = 26'h0000099;
      dc_req_block_data = {16{32'h0BADF00D}};
   endtask

   // Memory model: wait for a request, stall, accept, respond after lat cycles
   task automatic mem_serve(input int stall, input int lat, input logic [DW-1:0] data,
                            input logic [AW-1:0] exp_addr, input bit do_resp);
      int n = 0;
      while (!mem_req_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!mem_req_valid) begin
         fail("mem_req_timeout");
         return;
      end
      chk("busy_in_issue", busy, 1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall_valid_held", mem_req_valid, 1);
         chk("stall_addr_held", mem_req_block_addr, exp_addr);
         chk("stall_no_ic_grant", ic_req_ready, 0);
         chk("stall_no_dc_grant", dc_req_ready, 0);
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      for (int i = 1; i < lat; i++) begin
         @(posedge clk); #1;
      end
      if (do_resp) begin
         mem_resp_valid      = 1'b1;
         mem_resp_block_data = data;
         @(posedge clk); #1;
         mem_resp_valid      = 1'b0;
         mem_resp_block_data = '0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
      chk({tag, "_ic_req_ready"}, ic_req_ready, 0);
      chk({tag, "_dc_req_ready"}, dc_req_ready, 0);
      chk({tag, "_ic_resp_valid"}, ic_resp_valid, 0);
      chk({tag, "_dc_resp_valid"}, dc_resp_valid, 0);
      chk({tag, "_mem_req_addr"}, mem_req_block_addr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_aL              = 1'b0;
      ic_req_valid        = 1'b1;   // ready must stay low under reset
      ic_req_block_addr   = 26'h0000001;
      dc_req_valid        = 1'b1;
      dc_req_type         = 1'b0;
      dc_req_block_addr   = 26'h0000002;
      dc_req_block_data   = '0;
      mem_req_ready       = 1'b0;
      mem_resp_valid      = 1'b0;
      mem_resp_block_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
      rst_aL       = 1'b1;
      @(posedge clk); #1;

      // 1: IC-only read, response after 5 cycles
      push_mem(1'b0, 26'h0000040, '0, 1'b0);
      push_resp(1'b0, {64{8'hA5}});
      fork
         ic_request(26'h0000040);
         mem_serve(0, 5, {64{8'hA5}}, 26'h0000040, 1'b1);
      join
      @(negedge clk);
      chk("t1_idle_after", busy, 0);

      // 2: simultaneous pairs after reset; D-cache wins first, then alternation
      @(posedge clk); #1;
      rst_aL = 1'b0;
      @(posedge clk); #1;
      rst_aL = 1'b1;
      push_mem(1'b0, 26'h0000020, '0, 1'b0);
      push_resp(1'b1, {16{32'h11111111}});
      push_mem(1'b0, 26'h0000010, '0, 1'b0);
      push_resp(1'b0, {16{32'h22222222}});
      fork
         ic_request(26'h0000010);
         dc_request(1'b0, 26'h0000020, {16{32'hCAFECAFE}});
         begin
            mem_serve(0, 2, {16{32'h11111111}}, 26'h0000020, 1'b1);
            mem_serve(0, 1, {16{32'h22222222}}, 26'h0000010, 1'b1);
         end
      join
      push_mem(1'b0, 26'h0000021, '0, 1'b0);
      push_resp(1'b1, {16{32'h33333333}});
      push_mem(1'b0, 26'h0000011, '0, 1'b0);
      push_resp(1'b0, {16{32'h44444444}});
      fork
         ic_request(26'h0000011);
         dc_request(1'b0, 26'h0000021, '0);
         begin
            mem_serve(0, 3, {16{32'h33333333}}, 26'h0000021, 1'b1);
            mem_serve(0, 2, {16{32'h44444444}}, 26'h0000011, 1'b1);
         end
      join

      // 3: D-cache writeback
      push_mem(1'b1, 26'h00003FF, {16{32'hDEADBEEF}}, 1'b1);
      push_resp(1'b1, '0);
      fork
         dc_request(1'b1, 26'h00003FF, {16{32'hDEADBEEF}});
         mem_serve(0, 3, '0, 26'h00003FF, 1'b1);
      join

      // 4: memory backpressure; requester drops valid and changes fields,
      // an I-cache request arrives meanwhile and must wait
      push_mem(1'b0, 26'h0000055, '0, 1'b0);
      push_resp(1'b1, {16{32'h55555555}});
      push_mem(1'b0, 26'h0000077, '0, 1'b0);
      push_resp(1'b0, {16{32'h77777777}});
      fork
         dc_request(1'b0, 26'h0000055, '0);
         begin
            repeat (2) @(posedge clk);
            #1;
            ic_request(26'h0000077);
         end
         begin
            mem_serve(4, 2, {16{32'h55555555}}, 26'h0000055, 1'b1);
            mem_serve(0, 2, {16{32'h77777777}}, 26'h0000077, 1'b1);
         end
      join

      // 5: reset while waiting for the response; late response is dropped
      push_mem(1'b0, 26'h0000123, '0, 1'b0);
      fork
         dc_request(1'b0, 26'h0000123, '0);
         mem_serve(0, 2, '0, 26'h0000123, 1'b0);
      join
      @(negedge clk);
      chk("t5_busy_in_wait", busy, 1);
      @(posedge clk); #1;
      rst_aL = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_aL              = 1'b1;
      mem_resp_valid      = 1'b1;
      mem_resp_block_data = {16{32'hBAADBAAD}};
      @(negedge clk);
      chk("t5_no_ic_resp", ic_resp_valid, 0);
      chk("t5_no_dc_resp", dc_resp_valid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_no_mem_req", mem_req_valid, 0);
      @(posedge clk); #1;
      mem_resp_valid      = 1'b0;
      mem_resp_block_data = '0;

      // 6: spurious response in IDLE, then a normal request
      @(posedge clk); #1;
      mem_resp_valid      = 1'b1;
      mem_resp_block_data = {64{8'hFF}};
      @(negedge clk);
      chk("t6_no_ic_resp", ic_resp_valid, 0);
      chk("t6_no_dc_resp", dc_resp_valid, 0);
      chk("t6_busy", busy, 0);
      @(posedge clk); #1;
      mem_resp_valid      = 1'b0;
      mem_resp_block_data = '0;
      @(negedge clk);
      chk("t6_still_idle", busy, 0);
      @(posedge clk); #1;
      push_mem(1'b0, 26'h00002A0, '0, 1'b0);
      push_resp(1'b0, {16{32'h600D600D}});
      fork
         ic_request(26'h00002A0);
         mem_serve(0, 2, {16{32'h600D600D}}, 26'h00002A0, 1'b1);
      join

      repeat (3) @(posedge clk);
      #1;
      chk("mem_queue_drained", exp_mem_q.size(), 0);
      chk("resp_queue_drained", exp_resp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_mem_ctrl_arbiter
`default_nettype wire
